// File: rtl/tt_sweep_pkg.sv
// Shared types and sizing helpers for the exhaustive truth-table sweep harness.
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam int N_IN_DEF = 7;
    localparam int TT_W     = 1 << N_IN_DEF;
    localparam int IDX_W    = N_IN_DEF + 1;

    // Number of hex digits in the classification signature for an n-input function.
    function automatic int tt_hex_width(input int n_in);
        return ((1 << n_in) + 3) / 4;
    endfunction

endpackage

// File: rtl/tt_sweep_capture_settle_timer.sv
// Settle timer: counts up to SETTLE while enabled and raises a one-cycle
// sample strobe once x has been stable for SETTLE+1 cycles.
module tt_settle_timer #(
    parameter int SETTLE = 0
) (
    input  logic clk,
    input  logic srst,
    input  logic clr,
    input  logic en,
    output logic strobe
);

    logic [3:0] settle_cnt_reg;
    logic [3:0] settle_cnt_next;

    assign strobe = en && (settle_cnt_reg == 4'(SETTLE));

    always_comb begin
        settle_cnt_next = settle_cnt_reg;
        if (clr) begin
            settle_cnt_next = 4'd0;
        end else if (strobe) begin
            settle_cnt_next = 4'd0;
        end else if (en) begin
            settle_cnt_next = settle_cnt_reg + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            settle_cnt_reg <= 4'd0;
        end else begin
            settle_cnt_reg <= settle_cnt_next;
        end
    end

endmodule

// File: rtl/tt_sweep_capture.sv
// Drives every input vector onto an external combinational function and captures
// its output into a truth table. Optional onset counter: define TT_ONSET_COUNT_EN.
module tt_sweep_capture
    import tt_sweep_pkg::*;
#(
    parameter int N_IN   = 7,
    parameter int SETTLE = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [N_IN-1:0]        x,
    input  logic                   f_in,
    output logic [(1<<N_IN)-1:0]   tt,
    output logic                   tt_valid
`ifdef TT_ONSET_COUNT_EN
    ,
    output logic [N_IN:0]          onset
`endif
);

    localparam int TT_BITS  = 1 << N_IN;
    localparam int IDX_BITS = N_IN + 1;

    state_t                state_reg, state_next;
    logic [IDX_BITS-1:0]   idx_reg, idx_next;
    logic [TT_BITS-1:0]    tt_reg, tt_next, tt_we;
    logic                  tt_valid_reg, tt_valid_next;
    logic                  accept;
    logic                  sample;

    tt_settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle (
        .clk    (clk),
        .srst   (rst),
        .clr    (accept),
        .en     (state_reg == RUN),
        .strobe (sample)
    );

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        tt_valid_next = tt_valid_reg;
        busy          = 1'b0;
        done          = 1'b0;
        accept        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    accept        = 1'b1;
                    state_next    = RUN;
                    idx_next      = '0;
                    tt_valid_next = 1'b0;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (sample) begin
                    if (idx_reg == IDX_BITS'(TT_BITS - 1)) begin
                        state_next = FIN;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            FIN: begin
                done          = 1'b1;
                tt_valid_next = 1'b1;
                idx_next      = '0;
                state_next    = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // One write-enable per table bit; only the bit addressed by idx is replaced.
    for (genvar gi = 0; gi < TT_BITS; gi++) begin : g_tt_we
        assign tt_we[gi] = sample && (idx_reg[N_IN-1:0] == N_IN'(gi));
    end

    assign tt_next = (tt_reg & ~tt_we) | (tt_we & {TT_BITS{f_in}});

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            idx_reg      <= '0;
            tt_reg       <= '0;
            tt_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            tt_reg       <= tt_next;
            tt_valid_reg <= tt_valid_next;
        end
    end

    assign x        = idx_reg[N_IN-1:0];
    assign tt       = tt_reg;
    assign tt_valid = tt_valid_reg;

`ifdef TT_ONSET_COUNT_EN
    logic [N_IN:0] onset_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            onset_reg <= '0;
        end else if (accept) begin
            onset_reg <= '0;
        end else if (sample && f_in) begin
            onset_reg <= onset_reg + 1'b1;
        end
    end

    assign onset = onset_reg;
`endif

endmodule
